cas_key_loader: RTL
===================

# cas_key_loader

Loads the 64-bit CAS-Lock key from the on-chip non-volatile key store into the `keyinput_*` port of a locked netlist (e.g. `c432_lock`). It accepts a serial bit stream under a valid/ready handshake and checks it with a CRC-8. The key is presented to the locked core only after a successful check. Failed loads are counted, and the loader locks out permanently after `MAX_FAIL` failures; only reset clears the lockout.

## Interface
- `KEY_W`, 64, key width; must be even (two CAS chains of `KEY_W/2`)
- `MAX_FAIL`, 3, failed loads tolerated before LOCKOUT; ≥1
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle pulse; begins a load (honoured in IDLE, DONE, ERROR)
- `zeroize` in 1: level; wipes key and returns to IDLE (does not clear fail count or lockout)
- `key_sdata` in 1: serial key/CRC bit
- `key_svalid` in 1: `key_sdata` valid
- `key_sready` out 1: loader accepts a bit this cycle
- `key_out` out `KEY_W`: drives `keyinput_0..KEY_W-1`; bit 0 = first key bit received
- `key_valid` out 1: `key_out` holds a checked key
- `key_err` out 1: last load failed its check
- `lockout` out 1: failure limit reached
- `busy` out 1: state is SHIFT, CRC, or CHECK
- `fail_cnt` out `$clog2(MAX_FAIL+1)`: saturating count of failed loads

## Operation
- States: IDLE, SHIFT, CRC, CHECK, DONE, ERROR, LOCKOUT.
- Transfer:
  - A bit transfers on a cycle where `key_svalid && key_sready`.
  - `key_sready` = 1 only in SHIFT and CRC.
- IDLE --`start`--> SHIFT.
  - On entry: clear bit counter, shadow register, CRC register, `key_valid`, `key_err`.
- SHIFT:
  - Transfer k (k = 0..`KEY_W`-1) writes `shadow[k]` and updates the CRC.
  - After transfer `KEY_W`-1 the next state is CRC (or CHECK when CRC is compiled out).
- CRC:
  - 8 transfers of the CRC byte, MSB first, fed into the same CRC register.
  - After the 8th transfer the next state is CHECK.
- CRC-8 definition:
  - Polynomial 0x07, init 0x00, one bit per transfer.
  - Update: `fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00)`.
- CHECK (one cycle):
  - Pass when residue == 0 → DONE: `key_out` ← shadow, `key_valid` ← 1.
  - Fail → `fail_cnt` += 1 (saturating). If the new count == `MAX_FAIL` → LOCKOUT; else → ERROR with `key_err` ← 1.
- DONE / ERROR: hold until `start` (new load) or `zeroize`.
  - A new load from DONE deasserts `key_valid` and zeros `key_out` on the first SHIFT cycle.
- LOCKOUT:
  - `key_out` = 0, `key_valid` = 0, `key_err` = 1, `lockout` = 1, `key_sready` = 0.
  - `start` and `zeroize` are ignored; only `rst` exits.
- `key_out` is 0 in every state except DONE. A partially shifted key is never visible.
- `start` in SHIFT, CRC, or CHECK is ignored.
- `zeroize` in any state except LOCKOUT, including mid-shift:
  - Next state IDLE; shadow, CRC, `key_out`, `key_valid`, `key_err` cleared.
  - `fail_cnt` is kept. An aborted load is not counted as a failure.
- `zeroize` and `start` asserted together: `zeroize` wins.
- `key_svalid` stalls of any length are allowed; the counters hold.

## Timing
- Reset values: state IDLE; `key_out` = 0, `key_valid` = 0, `key_err` = 0, `lockout` = 0, `busy` = 0, `key_sready` = 0, `fail_cnt` = 0.
- `start` at cycle t → `key_sready` = 1 at t+1.
- Last transfer at cycle n → CHECK at n+1 → `key_valid`, `key_err`, or `lockout` visible at n+2. Latency is the same in both builds.
- Minimum load with `key_svalid` held high: `KEY_W`+8+2 cycles after `start` (`KEY_W`+2 without CRC).
- `zeroize` at cycle t → all outputs cleared at t+1.
- All outputs are registered; no combinational input-to-output path except `key_sready` (state-decoded, still registered).

## Configuration
- `CAS_KEY_CRC_EN` defined:
  - The CRC state exists; 8 CRC bits follow the key.
  - A failed check increments `fail_cnt`.
- `CAS_KEY_CRC_EN` undefined:
  - The CRC state and CRC register are removed. SHIFT goes directly to CHECK, and CHECK always passes.
  - `fail_cnt` stays 0; `key_err` and `lockout` are tied 0.

## Structure
- Shared package `cas_lock_pkg`:
  - State enum `cas_ld_state_e`.
  - `CAS_CRC_POLY = 8'h07` and `CAS_CRC_W = 8`.
  - Function `cas_crc8_step(crc, bit)`.
- One sub-module `cas_crc8_serial`: CRC register with `clr`, `en`, `bit`, output `residue`. Instantiated only under `CAS_KEY_CRC_EN`.

## Test plan
- Zero key with CRC 0x00, `key_svalid` held high:
  - `key_valid` = 1 exactly 74 cycles after `start`.
  - `key_out` = 0, `key_err` = 0.
- Key 64'hA5A5_0F0F_3C3C_9696 with the CRC from the bench model, random `key_svalid` gaps:
  - `key_valid` = 1 and `key_out` matches exactly; `key_out` is 0 at every cycle before `key_valid` rises.
- Zero key with CRC 0x01, three times (`MAX_FAIL` = 3):
  - `key_err` after each load; `fail_cnt` reads 1, 2, 3.
  - `lockout` = 1 after the 3rd load; a later `start` leaves `key_sready` = 0; `rst` clears all.
- `zeroize` after 30 key bits:
  - IDLE next cycle; `busy` = 0, `key_out` = 0, `fail_cnt` unchanged.
  - A fresh good load then succeeds.
- `start` during SHIFT, and `start`+`zeroize` in the same cycle:
  - The first is ignored (counter unaffected); the second gives IDLE.
- Build without `CAS_KEY_CRC_EN`, key 64'hFFFF_FFFF_0000_0001:
  - `key_valid` 66 cycles after `start`; `key_err` never 1.

Source files
------------

// File: rtl/cas_lock_pkg.sv
// rtl/cas_lock_pkg.sv - shared loader states and serial CRC-8 step for the CAS-Lock key loader
package cas_lock_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CRC,
        S_CHECK,
        S_DONE,
        S_ERROR,
        S_LOCKOUT
    } cas_ld_state_e;

    localparam logic [7:0] CAS_CRC_POLY = 8'h07;
    localparam int         CAS_CRC_W    = 8;

    function automatic logic [CAS_CRC_W-1:0] cas_crc8_step(
        input logic [CAS_CRC_W-1:0] crc,
        input logic                 b
    );
        logic fb;
        fb = crc[CAS_CRC_W-1] ^ b;
        return {crc[CAS_CRC_W-2:0], 1'b0} ^ (fb ? CAS_CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cas_crc8_serial.sv
// rtl/cas_crc8_serial.sv - one-bit-per-cycle CRC-8 register; residue is zero after a matching CRC byte
module cas_crc8_serial
    import cas_lock_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 bit_in,
    output logic [CAS_CRC_W-1:0] residue
);

    logic [CAS_CRC_W-1:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_crc <= '0;
        end else if (en) begin
            r_crc <= cas_crc8_step(r_crc, bit_in);
        end
    end

    assign residue = r_crc;

endmodule

// File: rtl/cas_key_loader.sv
// rtl/cas_key_loader.sv - serial CAS-Lock key loader with CRC check and lockout (CRC build: CAS_KEY_CRC_EN)
module cas_key_loader
    import cas_lock_pkg::*;
#(
    parameter int KEY_W    = 64,
    parameter int MAX_FAIL = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          zeroize,
    input  logic                          key_sdata,
    input  logic                          key_svalid,
    output logic                          key_sready,
    output logic [KEY_W-1:0]              key_out,
    output logic                          key_valid,
    output logic                          key_err,
    output logic                          lockout,
    output logic                          busy,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int                 FC_W     = $clog2(MAX_FAIL + 1);
    localparam int                 CNT_W    = $clog2(KEY_W + CAS_CRC_W);
    localparam logic [CNT_W-1:0]   LAST_KEY = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0]   LAST_CRC = CNT_W'(CAS_CRC_W - 1);
    localparam logic [FC_W-1:0]    FAIL_LIM = FC_W'(MAX_FAIL);
`ifdef CAS_KEY_CRC_EN
    localparam cas_ld_state_e      S_AFTER_KEY = S_CRC;
`else
    localparam cas_ld_state_e      S_AFTER_KEY = S_CHECK;
`endif

    cas_ld_state_e    r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [KEY_W-1:0] r_shadow, r_key;
    logic             r_valid, r_err;
    logic [FC_W-1:0]  r_fail, w_fail_inc;
    logic             w_xfer, w_zero, w_start_ok, w_pass;

    assign key_sready = (r_state == S_SHIFT) || (r_state == S_CRC);
    assign w_xfer     = key_svalid && key_sready;
    assign w_zero     = zeroize && (r_state != S_LOCKOUT);
    assign w_start_ok = start && !zeroize &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    assign w_fail_inc = (r_fail == FAIL_LIM) ? r_fail : r_fail + FC_W'(1);

`ifdef CAS_KEY_CRC_EN
    logic [CAS_CRC_W-1:0] w_residue;

    cas_crc8_serial u_crc (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_zero || w_start_ok),
        .en      (w_xfer),
        .bit_in  (key_sdata),
        .residue (w_residue)
    );

    assign w_pass = (w_residue == '0);
`else
    assign w_pass = 1'b1;
`endif

    always_comb begin
        w_next = r_state;
        if (w_zero) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: if (w_start_ok) w_next = S_SHIFT;
                S_SHIFT:   if (w_xfer && (r_cnt == LAST_KEY)) w_next = S_AFTER_KEY;
                S_CRC:     if (w_xfer && (r_cnt == LAST_CRC)) w_next = S_CHECK;
                S_CHECK:   w_next = w_pass ? S_DONE
                                  : ((w_fail_inc == FAIL_LIM) ? S_LOCKOUT : S_ERROR);
                S_LOCKOUT: w_next = S_LOCKOUT;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Shadow fills from the top so the first received bit lands in bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_key    <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_fail   <= '0;
        end else begin
            r_state <= w_next;
            if (w_zero || w_start_ok) begin
                r_cnt    <= '0;
                r_shadow <= '0;
                r_key    <= '0;
                r_valid  <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                if (w_xfer) begin
                    if (r_state == S_SHIFT) begin
                        r_shadow <= {key_sdata, r_shadow[KEY_W-1:1]};
                    end
                    r_cnt <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
                end
                if (r_state == S_CHECK) begin
                    r_shadow <= '0;
                    if (w_pass) begin
                        r_key   <= r_shadow;
                        r_valid <= 1'b1;
                    end else begin
                        r_fail <= w_fail_inc;
                        r_err  <= 1'b1;
                    end
                end
            end
        end
    end

    assign key_out   = r_key;
    assign key_valid = r_valid;
    assign key_err   = r_err;
    assign fail_cnt  = r_fail;
    assign lockout   = (r_state == S_LOCKOUT);
    assign busy      = (r_state == S_SHIFT) || (r_state == S_CRC) || (r_state == S_CHECK);

endmodule
